// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file op sequencer: default widths,
// command opcodes and the sequencer FSM state encoding.
package regfile_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;

    localparam logic [1:0] OP_MOVI = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// Command channel between decode (master) and the sequencer (slave):
// valid/ready command handshake plus the done pulse and held result.
interface regfile_op_sequencer_if #(
    parameter int DATA_W = regfile_pkg::RF_DATA_W,
    parameter int ADDR_W = regfile_pkg::RF_ADDR_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rn;
    logic [ADDR_W-1:0] cmd_rm;
    logic [DATA_W-1:0] cmd_imm;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm,
        input  cmd_ready, done, result
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm,
        output cmd_ready, done, result
    );
endinterface

// File: rtl/Register_file.sv
// 8x16 register file: synchronous write, combinational read.
module Register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [ADDR_W-1:0] readnum,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] regs [2**ADDR_W];

    // Write port.
    always_ff @(posedge clk) begin
        if (write) regs[writenum] <= data_in;
    end

    assign data_out = regs[readnum];

endmodule

// File: rtl/regfile_op_sequencer_alu.sv
// Write-back data selection: immediate, move, or modulo-2**DATA_W add/sub.
module seq_alu
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] y
);

    // Carry/borrow fall off the top naturally at DATA_W bits.
    always_comb begin
        y = imm;
        case (op)
            OP_MOVI: y = imm;
            OP_MOV:  y = b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            default: y = imm;
        endcase
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Multi-cycle controller owning all register-file ports. Takes one command at
// a time, reads operands through the single read port, then writes back.
module regfile_op_sequencer
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_op_sequencer_if.slave cmd,
    output logic                 rf_write,
    output logic [ADDR_W-1:0]    rf_writenum,
    output logic [ADDR_W-1:0]    rf_readnum,
    output logic [DATA_W-1:0]    rf_data_in,
    input  logic [DATA_W-1:0]    rf_data_out
);

    state_t            state_q, state_d;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] rd_q, rn_q, rm_q;
    logic [ADDR_W-1:0] readnum_q, readnum_d;
    logic [DATA_W-1:0] imm_q, reg_a, reg_b, result_q, alu_y;
    logic              ready, done_p, wr_en, accept;

    assign accept = cmd.cmd_valid && ready;

    // Next state and per-state strobes; rf_write decodes straight from the
    // state register so an async reset drops it immediately.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        done_p    = 1'b0;
        wr_en     = 1'b0;
        readnum_d = readnum_q;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (cmd.cmd_valid) begin
                    case (cmd.cmd_op)
                        OP_MOVI: state_d = S_WB;
                        OP_MOV:  state_d = S_RD_B;
                        default: state_d = S_RD_A;
                    endcase
                end
            end
            S_RD_A: begin
                readnum_d = rn_q;
                state_d   = S_RD_B;
            end
            S_RD_B: begin
                readnum_d = rm_q;
                state_d   = S_WB;
            end
            S_WB: begin
                wr_en   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_p  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Latch the command at acceptance; cmd_* is ignored afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= '0;
            rd_q  <= '0;
            rn_q  <= '0;
            rm_q  <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= cmd.cmd_op;
            rd_q  <= cmd.cmd_rd;
            rn_q  <= cmd.cmd_rn;
            rm_q  <= cmd.cmd_rm;
            imm_q <= cmd.cmd_imm;
        end
    end

    // Operand capture before WB (so rd==rn/rm sees the old value), result
    // load on the WB exit edge, and read index hold between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_a     <= '0;
            reg_b     <= '0;
            result_q  <= '0;
            readnum_q <= '0;
        end else begin
            readnum_q <= readnum_d;
            if (state_q == S_RD_A) reg_a    <= rf_data_out;
            if (state_q == S_RD_B) reg_b    <= rf_data_out;
            if (state_q == S_WB)   result_q <= alu_y;
        end
    end

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op  (op_q),
        .a   (reg_a),
        .b   (reg_b),
        .imm (imm_q),
        .y   (alu_y)
    );

    assign rf_write      = wr_en;
    assign rf_writenum   = rd_q;
    assign rf_readnum    = readnum_d;
    assign rf_data_in    = alu_y;
    assign cmd.cmd_ready = ready;
    assign cmd.done      = done_p;
    assign cmd.result    = result_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer driving a real Register_file. The driver
// pushes the expected write-back per accepted command; a monitor checks the
// write port, the done pulse, result and latency against the queue.
module tb_regfile_op_sequencer;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    regfile_op_sequencer_if #(.DATA_W(RF_DATA_W), .ADDR_W(RF_ADDR_W)) bus ();

    logic                 rf_write;
    logic [RF_ADDR_W-1:0] rf_writenum, rf_readnum;
    logic [RF_DATA_W-1:0] rf_data_in, rf_data_out;

    regfile_op_sequencer #(.DATA_W(RF_DATA_W), .ADDR_W(RF_ADDR_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd         (bus.slave),
        .rf_write    (rf_write),
        .rf_writenum (rf_writenum),
        .rf_readnum  (rf_readnum),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out)
    );

    Register_file #(.DATA_W(RF_DATA_W), .ADDR_W(RF_ADDR_W)) u_rf (
        .clk      (clk),
        .write    (rf_write),
        .writenum (rf_writenum),
        .readnum  (rf_readnum),
        .data_in  (rf_data_in),
        .data_out (rf_data_out)
    );

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   wr_cnt = 0;
    bit   abort_ok = 1'b0;

    // Edge counter; read right after an edge it still holds the pre-edge count.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every write and every done pulse must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rf_write) begin
                    if (sb.size() == 0) begin
                        if (!abort_ok) chk("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        wr_cnt++;
                        chk("writenum", 32'(rf_writenum), 32'(sb[0].rd));
                        chk("data_in", 32'(rf_data_in), 32'(sb[0].data));
                    end
                end
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", 32'(bus.result), 32'(e.data));
                        chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                        chk("writes_per_cmd", 32'(wr_cnt), 32'd1);
                        chk("ready_in_done", 32'(bus.cmd_ready), 32'd0);
                    end
                    wr_cnt = 0;
                end
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic [15:0] imm);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rn    = rn;
        bus.cmd_rm    = rm;
        bus.cmd_imm   = imm;
    endtask

    // Present a command and return once it has been accepted.
    task automatic accept_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                              input logic [2:0] rm, input logic [15:0] imm, output int acc);
        int t = 0;
        @(negedge clk);
        drive(op, rd, rn, rm, imm);
        while (!bus.cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        acc = cyc;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!bus.done && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            chk("done_timeout", 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic [15:0] imm,
                         input logic [15:0] exp_data, input int lat);
        int acc;
        accept_cmd(op, rd, rn, rm, imm, acc);
        sb.push_back('{rd, exp_data, lat, acc});
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        wait_done();
    endtask

    initial begin
        int acc;
        int t;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rd    = '0;
        bus.cmd_rn    = '0;
        bus.cmd_rm    = '0;
        bus.cmd_imm   = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_write", 32'(rf_write), 32'd0);
        chk("rst_writenum", 32'(rf_writenum), 32'd0);
        chk("rst_readnum", 32'(rf_readnum), 32'd0);
        chk("rst_data_in", 32'(rf_data_in), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        reset_n = 1'b1;

        // 1: MOVI R0=3, result held afterwards.
        issue(OP_MOVI, 3'd0, 3'd0, 3'd0, 16'h0003, 16'h0003, 2);
        repeat (2) @(negedge clk);
        chk("result_held", 32'(bus.result), 32'h0003);

        // 2: ADD R3 = R1 + R2.
        issue(OP_MOVI, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0005, 2);
        issue(OP_MOVI, 3'd2, 3'd0, 3'd0, 16'h0007, 16'h0007, 2);
        issue(OP_ADD,  3'd3, 3'd1, 3'd2, 16'h0000, 16'h000C, 4);

        // 3: SUB wrap, rd==rn; ADD carry dropped.
        issue(OP_MOVI, 3'd4, 3'd0, 3'd0, 16'h0000, 16'h0000, 2);
        issue(OP_MOVI, 3'd5, 3'd0, 3'd0, 16'h0001, 16'h0001, 2);
        issue(OP_SUB,  3'd4, 3'd4, 3'd5, 16'h0000, 16'hFFFF, 4);
        issue(OP_ADD,  3'd6, 3'd4, 3'd5, 16'h0000, 16'h0000, 4);

        // 4: MOV R7<-R3 with cmd_valid held and cmd_* churning.
        accept_cmd(OP_MOV, 3'd7, 3'd0, 3'd3, 16'h1234, acc);
        sb.push_back('{3'd7, 16'h000C, 3, acc});
        t = 0;
        while (t < 20) begin
            @(negedge clk);
            if (bus.done) break;
            chk("ready_busy", 32'(bus.cmd_ready), 32'd0);
            drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 16'($urandom));
            t++;
        end
        if (t >= 20) begin
            chk("hold_timeout", 32'd1, 32'd0);
            sb.delete();
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_done", 32'(bus.cmd_ready), 32'd1);

        // 5: reset during WB of MOVI R0=0xAAAA.
        abort_ok = 1'b1;
        accept_cmd(OP_MOVI, 3'd0, 3'd0, 3'd0, 16'hAAAA, acc);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_wb", 32'(rf_write), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_write", 32'(rf_write), 32'd0);
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        abort_ok = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end

        // 6: ADD R1 = R1 + R1 with R1=0x8001, then copy R1 to confirm the write.
        issue(OP_MOVI, 3'd1, 3'd0, 3'd0, 16'h8001, 16'h8001, 2);
        issue(OP_ADD,  3'd1, 3'd1, 3'd1, 16'h0000, 16'h0002, 4);
        issue(OP_MOV,  3'd2, 3'd0, 3'd1, 16'h0000, 16'h0002, 3);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
